apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

APB initiator that turns the register-space request/acknowledge handshakes (rreq/rack for reads, wreq/wack for writes) into APB3/APB4 transfers, making it the master-side counterpart of the APB register-space slave adapter. It sits between an internal config agent (CPU-less sequencer, debug port or test engine) and any APB slave. Transfers are serialised one at a time, read and write requests are arbitrated round-robin, and a timeout counter terminates hung transfers with an error.

## Interface
- ADDR_W, 16, address width
- DATA_W, 32, data width (multiple of 8)
- PROT, 3'b000, constant driven on p_prot
- TIMEOUT, 255, maximum ACCESS cycles per transfer; 0 disables the timeout

- clk  in  1  sole clock; every flop is rising-edge
- rst  in  1  reset, asynchronous and active-high
- rreq_addr  in  ADDR_W  read address
- rreq_vld / rreq_rdy  in / out  1  read request handshake
- rack_data  out  DATA_W  read data
- rack_err  out  1  read error: slave p_slverr or timeout
- rack_vld / rack_rdy  out / in  1  read acknowledge handshake
- wreq_addr  in  ADDR_W;  wreq_data  in  DATA_W;  wreq_strb  in  DATA_W/8
- wreq_vld / wreq_rdy  in / out  1  write request handshake
- wack_err  out  1;  wack_vld / wack_rdy  out / in  1  write acknowledge
- p_addr  out  ADDR_W;  p_prot  out  3;  p_sel, p_enable, p_write  out  1
- p_wdata  out  DATA_W;  p_strb  out  DATA_W/8
- p_ready, p_slverr  in  1;  p_rdata  in  DATA_W

## Operation
- FSM states: IDLE, SETUP, ACCESS, RACK, WACK. Reset state is IDLE.
- IDLE
  - rreq_rdy = rreq_vld && grant_rd.
  - wreq_rdy = wreq_vld && !grant_rd.
  - grant_rd = rreq_vld && (!wreq_vld || last_was_write).
  - last_was_write resets to 0, so a write wins the first simultaneous request.
  - The accepted request latches address, write flag, data and strobe into registers, then the FSM moves to SETUP.
  - Both rdy signals are 0 in every state other than IDLE.
- SETUP: p_sel=1, p_enable=0 for exactly one cycle; next state ACCESS. The timeout counter clears.
- ACCESS
  - p_sel=1, p_enable=1. p_addr, p_write, p_wdata and p_strb hold the values driven in SETUP.
  - p_ready=1: latch rdata (reads only) and err=p_slverr, then go to RACK or WACK.
  - p_ready=0 with cnt==TIMEOUT-1 and TIMEOUT!=0: timeout. Set err=1, rdata=0, go to the ack state.
  - Otherwise increment cnt. cnt is $clog2(TIMEOUT+1) bits wide and saturates.
  - p_ready wins over the timeout when both occur in the same cycle.
- RACK/WACK: hold vld=1 with stable data and err until rdy=1, then return to IDLE. last_was_write is updated on that handshake.
- APB signals outside SETUP/ACCESS
  - p_sel=0, p_enable=0.
  - p_addr, p_write, p_wdata and p_strb hold their last values.
  - p_wdata and p_strb are 0 on read transfers.
- p_prot is always PROT.
- p_slverr is sampled only when p_ready=1.

## Timing
- Reset values: all rdy/vld/sel/enable/write outputs 0; rack_data 0; err outputs 0; p_addr/p_wdata/p_strb 0.
- Reset asserted mid-transfer: APB drops p_sel and p_enable immediately (async) and the FSM returns to IDLE. No ack is generated for the aborted request.
- Latency with zero wait states: request handshake in cycle T, SETUP in T+1, ACCESS in T+2 with p_ready sampled there, ack vld in T+3. Each APB wait state adds 1 cycle.
- Maximum throughput is one transfer per 4 cycles when acks are accepted immediately. The next request handshake can occur in the cycle after the ack handshake.
- Requests held while the FSM is busy stay pending and are not dropped. Requesters must keep vld asserted with stable payload until rdy.
- Ack outputs are registered. rack_data is stable from vld until the handshake completes.

## Test plan
- Single write: addr 0x0010, data 0xDEADBEEF, strb 0xF, p_ready=1 in the first ACCESS cycle -> SETUP at T+1, ACCESS at T+2 with p_write=1, wack_vld=1 at T+3, wack_err=0.
- Read with 3 wait states: slave returns 0x12345678 on the 4th ACCESS cycle -> rack_data=0x12345678, rack_vld at T+6, p_sel/p_addr stable throughout.
- Simultaneous rreq and wreq out of reset, both held -> write issued first, then read, then write again (round-robin). rdy never asserts outside IDLE.
- TIMEOUT=4 with p_ready held 0 -> exactly 4 ACCESS cycles, then p_sel drops and rack_err=1 with rack_data=0. In a repeat run p_ready=1 on the 4th cycle -> normal completion, err=0.
- p_slverr=1 with p_ready=1 on a write -> wack_err=1. With rack_rdy held 0 for 5 cycles on a read -> rack_vld and rack_data stay stable and no new request is accepted.
- rst pulsed during ACCESS -> p_sel and p_enable go 0 asynchronously, no ack is produced, and a subsequent read completes normally.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if
//   Bundles the register-space request/acknowledge handshakes and the APB
//   bus of apb_master_bridge.
//   master : view of the bridge (drives rdy, ack and APB request signals)
//   slave  : view of the environment (requesters, ack sinks, APB slave)
//   Ports  : none; ADDR_W/DATA_W size the address and data fields.
interface apb_master_bridge_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) ();
   localparam int STRB_W = DATA_W / 8;

   // read request / acknowledge
   logic [ADDR_W-1:0] rreq_addr;
   logic              rreq_vld;
   logic              rreq_rdy;
   logic [DATA_W-1:0] rack_data;
   logic              rack_err;
   logic              rack_vld;
   logic              rack_rdy;

   // write request / acknowledge
   logic [ADDR_W-1:0] wreq_addr;
   logic [DATA_W-1:0] wreq_data;
   logic [STRB_W-1:0] wreq_strb;
   logic              wreq_vld;
   logic              wreq_rdy;
   logic              wack_err;
   logic              wack_vld;
   logic              wack_rdy;

   // APB
   logic [ADDR_W-1:0] p_addr;
   logic [2:0]        p_prot;
   logic              p_sel;
   logic              p_enable;
   logic              p_write;
   logic [DATA_W-1:0] p_wdata;
   logic [STRB_W-1:0] p_strb;
   logic              p_ready;
   logic              p_slverr;
   logic [DATA_W-1:0] p_rdata;

   modport master (
      input  rreq_addr, rreq_vld, rack_rdy,
      output rreq_rdy, rack_data, rack_err, rack_vld,
      input  wreq_addr, wreq_data, wreq_strb, wreq_vld, wack_rdy,
      output wreq_rdy, wack_err, wack_vld,
      output p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
      input  p_ready, p_slverr, p_rdata
   );

   modport slave (
      output rreq_addr, rreq_vld, rack_rdy,
      input  rreq_rdy, rack_data, rack_err, rack_vld,
      output wreq_addr, wreq_data, wreq_strb, wreq_vld, wack_rdy,
      input  wreq_rdy, wack_err, wack_vld,
      input  p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
      output p_ready, p_slverr, p_rdata
   );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   APB initiator: converts read (rreq/rack) and write (wreq/wack) request
//   handshakes into serialised APB transfers. Reads and writes share the bus
//   and are arbitrated round-robin; a hung transfer is ended with an error
//   after TIMEOUT ACCESS cycles (TIMEOUT=0 waits forever).
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - apb_master_bridge_if.master: request/ack handshakes + APB bus
module apb_master_bridge #(
   parameter int         ADDR_W  = 16,
   parameter int         DATA_W  = 32,
   parameter logic [2:0] PROT    = 3'b000,
   parameter int         TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   apb_master_bridge_if.master bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      RACK   = 3'd3,
      WACK   = 3'd4
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic              write_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [STRB_W-1:0] strb_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              rack_err_reg;
   logic              wack_err_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              last_was_write_reg;

   logic grant_rd;
   logic rreq_rdy_c, wreq_rdy_c;
   logic p_sel_c, p_enable_c;
   logic rack_vld_c, wack_vld_c;
   logic timeout_hit;
   logic access_done;

   // p_ready has priority: a timeout only fires on a cycle without p_ready.
   assign timeout_hit = (TIMEOUT != 0) && !bus.p_ready && (cnt_reg == CNT_LAST);
   assign access_done = bus.p_ready || timeout_hit;

   // State register. p_sel/p_enable decode straight from this register, so
   // the async reset drops them immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (rreq_rdy_c || wreq_rdy_c) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (access_done) state_next = write_reg ? WACK : RACK;
         RACK:    if (bus.rack_rdy) state_next = IDLE;
         WACK:    if (bus.wack_rdy) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode. A read is granted only if no write competes, or if the
   // previous completed transfer was a write (round-robin).
   always_comb begin
      grant_rd   = bus.rreq_vld && (!bus.wreq_vld || last_was_write_reg);
      rreq_rdy_c = 1'b0;
      wreq_rdy_c = 1'b0;
      p_sel_c    = 1'b0;
      p_enable_c = 1'b0;
      rack_vld_c = 1'b0;
      wack_vld_c = 1'b0;
      case (state_reg)
         IDLE: begin
            rreq_rdy_c = bus.rreq_vld && grant_rd;
            wreq_rdy_c = bus.wreq_vld && !grant_rd;
         end
         SETUP:   p_sel_c = 1'b1;
         ACCESS: begin
            p_sel_c    = 1'b1;
            p_enable_c = 1'b1;
         end
         RACK:    rack_vld_c = 1'b1;
         WACK:    wack_vld_c = 1'b1;
         default: ;
      endcase
   end

   // Request capture, response capture, timeout counter, arbitration history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg           <= '0;
         write_reg          <= 1'b0;
         wdata_reg          <= '0;
         strb_reg           <= '0;
         rdata_reg          <= '0;
         rack_err_reg       <= 1'b0;
         wack_err_reg       <= 1'b0;
         cnt_reg            <= '0;
         last_was_write_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (rreq_rdy_c) begin
                  addr_reg  <= bus.rreq_addr;
                  write_reg <= 1'b0;
                  wdata_reg <= '0;   // reads present zero write data/strobes
                  strb_reg  <= '0;
               end else if (wreq_rdy_c) begin
                  addr_reg  <= bus.wreq_addr;
                  write_reg <= 1'b1;
                  wdata_reg <= bus.wreq_data;
                  strb_reg  <= bus.wreq_strb;
               end
            end
            SETUP: cnt_reg <= '0;
            ACCESS: begin
               if (bus.p_ready) begin
                  if (write_reg) begin
                     wack_err_reg <= bus.p_slverr;
                  end else begin
                     rdata_reg    <= bus.p_rdata;
                     rack_err_reg <= bus.p_slverr;
                  end
               end else if (timeout_hit) begin
                  if (write_reg) begin
                     wack_err_reg <= 1'b1;
                  end else begin
                     rdata_reg    <= '0;
                     rack_err_reg <= 1'b1;
                  end
               end else if (cnt_reg != CNT_MAX) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            RACK: if (bus.rack_rdy) last_was_write_reg <= 1'b0;
            WACK: if (bus.wack_rdy) last_was_write_reg <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.rreq_rdy  = rreq_rdy_c;
   assign bus.wreq_rdy  = wreq_rdy_c;
   assign bus.rack_vld  = rack_vld_c;
   assign bus.wack_vld  = wack_vld_c;
   assign bus.rack_data = rdata_reg;
   assign bus.rack_err  = rack_err_reg;
   assign bus.wack_err  = wack_err_reg;
   assign bus.p_sel     = p_sel_c;
   assign bus.p_enable  = p_enable_c;
   assign bus.p_addr    = addr_reg;
   assign bus.p_write   = write_reg;
   assign bus.p_wdata   = wdata_reg;
   assign bus.p_strb    = strb_reg;
   assign bus.p_prot    = PROT;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge (TIMEOUT=4, PROT=3'b101).
//   Expected results come from a transfer-level model: access count,
//   ack latency, data and error follow from the planned wait states and
//   the timeout limit; arbitration follows the round-robin rule.
module tb_apb_master_bridge;
   localparam int         TO    = 4;
   localparam logic [2:0] PROTV = 3'b101;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   apb_master_bridge_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   apb_master_bridge #(
      .ADDR_W(16), .DATA_W(32), .PROT(PROTV), .TIMEOUT(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   bit m_last_wr;   // model: type of last completed transfer

   // observations of the most recent run_xfer
   bit          o_hang, o_pstable, o_ack_stable, o_rdy_leak, o_sel_at_ack, o_vld_after;
   int          o_setup_n, o_access_n, o_ack_t, o_first_access_t;
   logic        o_pwrite, o_err;
   logic [15:0] o_paddr;
   logic [31:0] o_pwdata, o_data;
   logic [3:0]  o_pstrb;

   function automatic int exp_access(input int waits);
      return (waits < TO) ? waits + 1 : TO;
   endfunction

   // Drives one request, plays the APB slave with `waits` wait states and
   // holds the ack for `ack_hold` cycles; records what it saw (no checking).
   // Cycle t=1 is the cycle after the request handshake.
   task automatic run_xfer(input bit wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int waits, input logic [31:0] rd,
                           input bit serr, input int ack_hold, input bit poke);
      bit got, done;
      int t, acc, hold;
      o_hang = 0; o_setup_n = 0; o_access_n = 0; o_ack_t = -1; o_first_access_t = -1;
      o_pstable = 1; o_ack_stable = 1; o_rdy_leak = 0; o_sel_at_ack = 0; o_vld_after = 0;
      o_data = '0; o_err = 0; o_pwrite = 0; o_paddr = '0; o_pwdata = '0; o_pstrb = '0;
      @(negedge clk);
      if (wr) begin
         bus.wreq_addr = a; bus.wreq_data = d; bus.wreq_strb = s; bus.wreq_vld = 1'b1;
      end else begin
         bus.rreq_addr = a; bus.rreq_vld = 1'b1;
      end
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         if (wr ? bus.wreq_rdy : bus.rreq_rdy) got = 1;
         else @(negedge clk);
      end
      @(negedge clk);
      bus.rreq_vld = 1'b0; bus.wreq_vld = 1'b0;
      if (!got) begin
         o_hang = 1;
         return;
      end
      t = 1; acc = 0; hold = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (bus.rreq_rdy || bus.wreq_rdy) o_rdy_leak = 1;
         if (bus.p_sel && !bus.p_enable) begin
            o_setup_n++;
            o_paddr = bus.p_addr; o_pwrite = bus.p_write;
            o_pwdata = bus.p_wdata; o_pstrb = bus.p_strb;
            bus.p_ready = 1'b0;
         end else if (bus.p_sel && bus.p_enable) begin
            if (o_first_access_t < 0) o_first_access_t = t;
            if (bus.p_addr !== o_paddr || bus.p_write !== o_pwrite ||
                bus.p_wdata !== o_pwdata || bus.p_strb !== o_pstrb) o_pstable = 0;
            if (acc == waits) begin
               bus.p_ready = 1'b1; bus.p_rdata = rd; bus.p_slverr = serr;
            end else begin
               bus.p_ready = 1'b0; bus.p_rdata = $urandom;
               bus.p_slverr = 1'($urandom_range(0, 1));
            end
            acc++;
            o_access_n = acc;
         end else begin
            bus.p_ready = 1'b0;
         end
         if (wr ? bus.wack_vld : bus.rack_vld) begin
            if (o_ack_t < 0) begin
               o_ack_t = t; o_sel_at_ack = bus.p_sel;
               o_data = bus.rack_data; o_err = wr ? bus.wack_err : bus.rack_err;
            end else if ((!wr && bus.rack_data !== o_data) ||
                         ((wr ? bus.wack_err : bus.rack_err) !== o_err)) begin
               o_ack_stable = 0;
            end
            if (hold >= ack_hold) begin
               if (wr) bus.wack_rdy = 1'b1; else bus.rack_rdy = 1'b1;
               bus.rreq_vld = 1'b0; bus.wreq_vld = 1'b0;
               done = 1;
            end else begin
               hold++;
               if (poke) begin
                  // competing request while the ack is pending: must not be taken
                  bus.rreq_addr = 16'($urandom); bus.rreq_vld = 1'b1;
                  bus.wreq_addr = 16'($urandom); bus.wreq_vld = 1'b1;
               end
            end
         end
         t++;
         if (!done) @(negedge clk);
      end
      if (!done) o_hang = 1;
      @(negedge clk);
      o_vld_after = bus.rack_vld || bus.wack_vld;
      bus.rack_rdy = 1'b0; bus.wack_rdy = 1'b0; bus.p_ready = 1'b0;
      bus.rreq_vld = 1'b0; bus.wreq_vld = 1'b0;
      if (done) m_last_wr = wr;
   endtask

   task automatic test_reset();
      logic [8:0] ctl;
      rst = 1'b1;
      bus.rreq_addr = '0; bus.rreq_vld = 0; bus.rack_rdy = 0;
      bus.wreq_addr = '0; bus.wreq_data = '0; bus.wreq_strb = '0; bus.wreq_vld = 0; bus.wack_rdy = 0;
      bus.p_ready = 0; bus.p_slverr = 0; bus.p_rdata = '0;
      repeat (3) @(negedge clk);
      ctl = {bus.rreq_rdy, bus.wreq_rdy, bus.rack_vld, bus.wack_vld, bus.p_sel,
             bus.p_enable, bus.p_write, bus.rack_err, bus.wack_err};
      checks++; if (ctl !== 9'd0) begin errors++; $display("FAIL reset_ctl: got %b expected 0", ctl); end
      checks++; if (bus.p_addr !== 16'd0 || bus.p_strb !== 4'd0) begin errors++; $display("FAIL reset_addr_strb: got %h/%h expected 0/0", bus.p_addr, bus.p_strb); end
      checks++; if (bus.p_wdata !== 32'd0 || bus.rack_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", bus.p_wdata, bus.rack_data); end
      checks++; if (bus.p_prot !== PROTV) begin errors++; $display("FAIL p_prot: got %b expected %b", bus.p_prot, PROTV); end
      rst = 1'b0;
      m_last_wr = 0;
      @(negedge clk);
      checks++; if (bus.p_sel !== 1'b0 || bus.rack_vld !== 1'b0) begin errors++; $display("FAIL post_reset_idle: sel=%b rack_vld=%b expected 0", bus.p_sel, bus.rack_vld); end
   endtask

   task automatic test_arbitration();
      int grants, last_c, leak;
      bit rr, wr, exp_rd;
      grants = 0; last_c = -1; leak = 0;
      @(negedge clk);
      bus.rreq_addr = 16'h0AA0; bus.rreq_vld = 1'b1;
      bus.wreq_addr = 16'h0BB0; bus.wreq_data = 32'hCAFE0001; bus.wreq_strb = 4'h3; bus.wreq_vld = 1'b1;
      bus.p_ready = 1'b1; bus.p_slverr = 1'b0; bus.rack_rdy = 1'b1; bus.wack_rdy = 1'b1;
      for (int c = 0; c < 40 && grants < 3; c++) begin
         #1;
         rr = bus.rreq_rdy; wr = bus.wreq_rdy;
         if ((rr || wr) && (bus.p_sel || bus.rack_vld || bus.wack_vld)) leak++;
         if (rr && wr) leak++;
         if (rr || wr) begin
            exp_rd = m_last_wr;   // both pending: read wins only after a write
            checks++; if (rr !== exp_rd) begin errors++; $display("FAIL arb_order grant%0d: got read=%b expected read=%b", grants, rr, exp_rd); end
            if (grants > 0) begin
               checks++; if (c - last_c !== 4) begin errors++; $display("FAIL arb_gap: got %0d expected 4", c - last_c); end
            end
            m_last_wr = wr;
            grants++;
            last_c = c;
         end
         @(negedge clk);
      end
      bus.rreq_vld = 1'b0; bus.wreq_vld = 1'b0;
      repeat (3) @(negedge clk);
      bus.p_ready = 1'b0; bus.rack_rdy = 1'b0; bus.wack_rdy = 1'b0;
      checks++; if (grants !== 3) begin errors++; $display("FAIL arb_grants: got %0d expected 3", grants); end
      checks++; if (leak !== 0) begin errors++; $display("FAIL arb_rdy_leak: got %0d expected 0", leak); end
   endtask

   task automatic test_single_write();
      run_xfer(1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0, 0, 0);
      checks++; if (o_hang !== 0) begin errors++; $display("FAIL wr_hang: got %b expected 0", o_hang); end
      checks++; if (o_setup_n !== 1 || o_first_access_t !== 2) begin errors++; $display("FAIL wr_phases: setup_n=%0d access_t=%0d expected 1/2", o_setup_n, o_first_access_t); end
      checks++; if (o_pwrite !== 1'b1 || o_paddr !== 16'h0010) begin errors++; $display("FAIL wr_bus: write=%b addr=%h expected 1/0010", o_pwrite, o_paddr); end
      checks++; if (o_pwdata !== 32'hDEADBEEF || o_pstrb !== 4'hF) begin errors++; $display("FAIL wr_wdata: got %h/%h expected deadbeef/f", o_pwdata, o_pstrb); end
      checks++; if (o_ack_t !== 3 || o_err !== 1'b0) begin errors++; $display("FAIL wr_ack: t=%0d err=%b expected 3/0", o_ack_t, o_err); end
      checks++; if (o_vld_after !== 1'b0) begin errors++; $display("FAIL wr_vld_drop: got %b expected 0", o_vld_after); end
   endtask

   task automatic test_read_waits();
      run_xfer(0, 16'h0234, 32'h0, 4'h0, 3, 32'h12345678, 0, 0, 0);
      checks++; if (o_ack_t !== 6 || o_access_n !== 4) begin errors++; $display("FAIL rd3_timing: ack_t=%0d access_n=%0d expected 6/4", o_ack_t, o_access_n); end
      checks++; if (o_data !== 32'h12345678 || o_err !== 1'b0) begin errors++; $display("FAIL rd3_data: got %h err=%b expected 12345678/0", o_data, o_err); end
      checks++; if (o_pstable !== 1'b1 || o_paddr !== 16'h0234) begin errors++; $display("FAIL rd3_stable: stable=%b addr=%h expected 1/0234", o_pstable, o_paddr); end
      checks++; if (o_pwrite !== 1'b0 || o_pwdata !== 32'h0 || o_pstrb !== 4'h0) begin errors++; $display("FAIL rd3_rdfields: write=%b wdata=%h strb=%h expected 0/0/0", o_pwrite, o_pwdata, o_pstrb); end
   endtask

   task automatic test_timeout();
      run_xfer(0, 16'h0300, 32'h0, 4'h0, 1000, 32'h55AA55AA, 0, 0, 0);
      checks++; if (o_access_n !== TO || o_ack_t !== 2 + TO) begin errors++; $display("FAIL to_timing: access_n=%0d ack_t=%0d expected %0d/%0d", o_access_n, o_ack_t, TO, 2 + TO); end
      checks++; if (o_err !== 1'b1 || o_data !== 32'h0) begin errors++; $display("FAIL to_result: err=%b data=%h expected 1/0", o_err, o_data); end
      checks++; if (o_sel_at_ack !== 1'b0) begin errors++; $display("FAIL to_sel_drop: got %b expected 0", o_sel_at_ack); end
      run_xfer(1, 16'h0304, 32'h11112222, 4'h5, 1000, 32'h0, 0, 0, 0);
      checks++; if (o_err !== 1'b1 || o_access_n !== TO) begin errors++; $display("FAIL to_write: err=%b access_n=%0d expected 1/%0d", o_err, o_access_n, TO); end
      run_xfer(0, 16'h0308, 32'h0, 4'h0, TO - 1, 32'h0F0F1234, 0, 0, 0);
      checks++; if (o_err !== 1'b0 || o_data !== 32'h0F0F1234 || o_access_n !== TO) begin errors++; $display("FAIL to_edge: err=%b data=%h access_n=%0d expected 0/0f0f1234/%0d", o_err, o_data, o_access_n, TO); end
   endtask

   task automatic test_slverr_and_hold();
      run_xfer(1, 16'h0400, 32'h87654321, 4'hC, 1, 32'h0, 1, 0, 0);
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL slverr_wr: got %b expected 1", o_err); end
      run_xfer(0, 16'h0404, 32'h0, 4'h0, 0, 32'hA5A5F00D, 0, 5, 1);
      checks++; if (o_ack_stable !== 1'b1 || o_data !== 32'hA5A5F00D) begin errors++; $display("FAIL hold_stable: stable=%b data=%h expected 1/a5a5f00d", o_ack_stable, o_data); end
      checks++; if (o_rdy_leak !== 1'b0) begin errors++; $display("FAIL hold_no_accept: got %b expected 0", o_rdy_leak); end
      run_xfer(0, 16'h0408, 32'h0, 4'h0, 2, 32'h00C0FFEE, 1, 0, 0);
      checks++; if (o_err !== 1'b1 || o_data !== 32'h00C0FFEE) begin errors++; $display("FAIL slverr_rd: err=%b data=%h expected 1/00c0ffee", o_err, o_data); end
   endtask

   task automatic test_random();
      bit wr, serr;
      int waits, hold, ea;
      logic [15:0] a;
      logic [31:0] d, rd;
      logic [3:0] s;
      for (int i = 0; i < 16; i++) begin
         wr = 1'($urandom_range(0, 1)); serr = 1'($urandom_range(0, 1));
         waits = $urandom_range(0, 6); hold = $urandom_range(0, 2);
         a = 16'($urandom); d = $urandom; rd = $urandom; s = 4'($urandom);
         run_xfer(wr, a, d, s, waits, rd, serr, hold, 0);
         ea = exp_access(waits);
         checks++; if (o_hang !== 0 || o_ack_t !== 2 + ea || o_access_n !== ea) begin errors++; $display("FAIL rnd%0d_timing: hang=%b ack_t=%0d access_n=%0d expected 0/%0d/%0d", i, o_hang, o_ack_t, o_access_n, 2 + ea, ea); end
         checks++; if (o_err !== ((waits < TO) ? serr : 1'b1)) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b", i, o_err, (waits < TO) ? serr : 1'b1); end
         if (!wr) begin
            checks++; if (o_data !== ((waits < TO) ? rd : 32'h0)) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", i, o_data, (waits < TO) ? rd : 32'h0); end
         end
         checks++; if (o_paddr !== a || o_pwrite !== wr || o_pwdata !== (wr ? d : 32'h0) || o_pstrb !== (wr ? s : 4'h0)) begin errors++; $display("FAIL rnd%0d_bus: addr=%h w=%b wdata=%h strb=%h expected %h/%b/%h/%h", i, o_paddr, o_pwrite, o_pwdata, o_pstrb, a, wr, wr ? d : 32'h0, wr ? s : 4'h0); end
         checks++; if (o_pstable !== 1'b1 || o_ack_stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_stable: bus=%b ack=%b expected 1/1", i, o_pstable, o_ack_stable); end
      end
   endtask

   task automatic test_reset_mid();
      int vld_seen;
      @(negedge clk);
      bus.rreq_addr = 16'h0500; bus.rreq_vld = 1'b1;
      #1;
      checks++; if (bus.rreq_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_accept: got %b expected 1", bus.rreq_rdy); end
      @(negedge clk);
      bus.rreq_vld = 1'b0;
      @(negedge clk);
      checks++; if (bus.p_sel !== 1'b1 || bus.p_enable !== 1'b1) begin errors++; $display("FAIL rstmid_access: sel=%b en=%b expected 1/1", bus.p_sel, bus.p_enable); end
      bus.p_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.p_sel !== 1'b0 || bus.p_enable !== 1'b0) begin errors++; $display("FAIL rstmid_async: sel=%b en=%b expected 0/0", bus.p_sel, bus.p_enable); end
      @(negedge clk);
      rst = 1'b0;
      m_last_wr = 0;
      bus.rack_rdy = 1'b1;
      vld_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rack_vld || bus.wack_vld || bus.p_sel) vld_seen++;
      end
      bus.rack_rdy = 1'b0;
      checks++; if (vld_seen !== 0) begin errors++; $display("FAIL rstmid_no_ack: got %0d expected 0", vld_seen); end
      run_xfer(0, 16'h0504, 32'h0, 4'h0, 1, 32'h600DF00D, 0, 0, 0);
      checks++; if (o_ack_t !== 4 || o_data !== 32'h600DF00D || o_err !== 1'b0) begin errors++; $display("FAIL rstmid_after: ack_t=%0d data=%h err=%b expected 4/600df00d/0", o_ack_t, o_data, o_err); end
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_single_write();
      test_read_waits();
      test_timeout();
      test_slverr_and_hold();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
